// File: rtl/mcs4_pkg.sv
// mcs4_pkg
// Shared constants for the MCS-4 style bus master: subcycle (phase)
// encodings, FSM state encoding, divider default and bus widths.
// No ports; imported by mcs4_subcycle_timer and mcs4_bus_master.
package mcs4_pkg;

  localparam int ADDR_W = 12;
  localparam int NIB_W  = 4;
  localparam int PHASE_DIV_DEFAULT = 8;

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mcs4_subcycle_timer.sv
// mcs4_subcycle_timer
// Divides sysclk into bus subcycles of PHASE_DIV cycles and steps the
// 3-bit phase counter A1..X3.
// Ports:
//   sysclk   - clock (rising edge)
//   poc_n    - synchronous active-low reset (phase=A1, div=0)
//   start    - restart at A1 with div=0 (reset tail, WAIT exit)
//   run      - advance the divider this cycle
//   park     - at the X3 wrap, stay on X3 instead of returning to A1
//   phase    - current subcycle
//   div_last - divider is on the last cycle of the subcycle
module mcs4_subcycle_timer
  import mcs4_pkg::*;
#(
  parameter int PHASE_DIV = PHASE_DIV_DEFAULT
) (
  input  logic       sysclk,
  input  logic       poc_n,
  input  logic       start,
  input  logic       run,
  input  logic       park,
  output logic [2:0] phase,
  output logic       div_last
);

  localparam logic [7:0] DIV_LAST = 8'(PHASE_DIV - 1);

  logic [7:0] div;

  assign div_last = (div == DIV_LAST);

  // Phase only moves on the divider wrap; the 3-bit counter rolls X3->A1
  // naturally unless parked for WAIT.
  always_ff @(posedge sysclk) begin
    if (!poc_n || start) begin
      div   <= 8'd0;
      phase <= PH_A1;
    end else if (run) begin
      if (div_last) begin
        div <= 8'd0;
        if (!park)
          phase <= phase + 3'd1;
      end else begin
        div <= div + 8'd1;
      end
    end
  end

endmodule

// File: rtl/mcs4_bus_master.sv
// mcs4_bus_master
// Instruction-fetch bus master for a 4-bit multiplexed nibble bus.
// Drives the 12-bit address in A1..A3, reads opcode nibbles in M1/M2,
// optionally drives execute data in X2/X3, and can stall in WAIT.
// Ports:
//   sysclk, poc_n            - clock and synchronous active-low clear
//   data_i                   - nibble read from the responder
//   data_o, data_oe          - nibble driven and its drive enable
//   sync_n, cmrom_n          - instruction-cycle marker, ROM select
//   phase, pc                - current subcycle and fetch address
//   jmp_valid/addr, jmp_ack  - pc load request and its acknowledge
//   hold                     - stall before the next instruction cycle
//   x_drive, x2_data, x3_data- optional execute-phase data
//   instr_*                  - fetched-instruction strobe and contents
module mcs4_bus_master
  import mcs4_pkg::*;
#(
  parameter int          PHASE_DIV = PHASE_DIV_DEFAULT,
  parameter logic [11:0] PC_RESET  = 12'h000
) (
  input  logic              sysclk,
  input  logic              poc_n,
  input  logic [NIB_W-1:0]  data_i,
  output logic [NIB_W-1:0]  data_o,
  output logic              data_oe,
  output logic              sync_n,
  output logic              cmrom_n,
  output logic [2:0]        phase,
  output logic [ADDR_W-1:0] pc,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              jmp_ack,
  input  logic              hold,
  input  logic              x_drive,
  input  logic [NIB_W-1:0]  x2_data,
  input  logic [NIB_W-1:0]  x3_data,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [NIB_W-1:0]  instr_opr,
  output logic [NIB_W-1:0]  instr_opa
);

  state_t           state_q, state_d;
  logic             rst_q;
  logic             div_last;
  logic             tick_last, x3_end, wait_exit, a1_entry;
  logic [NIB_W-1:0] opr_q;
  logic             xdrv_q;

  // rst_q keeps the bus quiet and the timer parked at A1 for one cycle
  // after poc_n rises, so the first visible A1 is a full subcycle.
  always_ff @(posedge sysclk) begin
    if (!poc_n)
      rst_q <= 1'b1;
    else
      rst_q <= 1'b0;
  end

  assign tick_last = !rst_q && (state_q == ST_RUN) && div_last;
  assign x3_end    = tick_last && (phase == PH_X3);
  assign wait_exit = !rst_q && (state_q == ST_WAIT) && !hold;
  assign a1_entry  = (x3_end && !hold) || wait_exit;

  mcs4_subcycle_timer #(
    .PHASE_DIV(PHASE_DIV)
  ) u_timer (
    .sysclk  (sysclk),
    .poc_n   (poc_n),
    .start   (rst_q || wait_exit),
    .run     (!rst_q && (state_q == ST_RUN)),
    .park    ((phase == PH_X3) && hold),
    .phase   (phase),
    .div_last(div_last)
  );

  always_ff @(posedge sysclk) begin
    if (!poc_n)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (x3_end && hold)
      state_d = ST_WAIT;
    else if (wait_exit)
      state_d = ST_RUN;
  end

  // Nibble capture, instruction strobe, pc update. A jump at A1 entry
  // overrides the increment from the preceding M2.
  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      pc          <= PC_RESET;
      opr_q       <= '0;
      xdrv_q      <= 1'b0;
      instr_valid <= 1'b0;
      instr_addr  <= '0;
      instr_opr   <= '0;
      instr_opa   <= '0;
      jmp_ack     <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      jmp_ack     <= 1'b0;
      if (tick_last) begin
        case (phase)
          PH_M1: opr_q <= data_i;
          PH_M2: begin
            instr_valid <= 1'b1;
            instr_addr  <= pc;
            instr_opr   <= opr_q;
            instr_opa   <= data_i;
            pc          <= pc + 12'd1;
          end
          PH_X1: xdrv_q <= x_drive;
          default: ;
        endcase
      end
      if (a1_entry && jmp_valid) begin
        pc      <= jmp_addr;
        jmp_ack <= 1'b1;
      end
    end
  end

  // Bus outputs decode directly from phase; reset tail and WAIT idle the bus.
  always_comb begin
    data_oe = 1'b0;
    data_o  = '0;
    sync_n  = 1'b1;
    cmrom_n = 1'b1;
    if (!rst_q && (state_q == ST_RUN)) begin
      case (phase)
        PH_A1: begin data_oe = 1'b1; data_o = pc[3:0];  end
        PH_A2: begin data_oe = 1'b1; data_o = pc[7:4];  end
        PH_A3: begin data_oe = 1'b1; data_o = pc[11:8]; cmrom_n = 1'b0; end
        PH_X2: begin
          data_oe = xdrv_q;
          if (xdrv_q) data_o = x2_data;
        end
        PH_X3: begin
          sync_n  = 1'b0;
          data_oe = xdrv_q;
          if (xdrv_q) data_o = x3_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcs4_bus_master.sv
// tb_mcs4_bus_master
// Directed bench for mcs4_bus_master at PHASE_DIV=2 (16 sysclk per
// instruction cycle). A small ROM responder answers M1/M2 from pc:
// opr = D ^ pc[3:0], opa = 1 + pc[11:8].
module tb_mcs4_bus_master;
  import mcs4_pkg::*;

  logic        sysclk = 1'b0;
  logic        poc_n;
  logic [3:0]  data_i;
  logic [3:0]  data_o;
  logic        data_oe, sync_n, cmrom_n;
  logic [2:0]  phase;
  logic [11:0] pc;
  logic        jmp_valid;
  logic [11:0] jmp_addr;
  logic        jmp_ack;
  logic        hold;
  logic        x_drive;
  logic [3:0]  x2_data, x3_data;
  logic        instr_valid;
  logic [11:0] instr_addr;
  logic [3:0]  instr_opr, instr_opa;

  int checks = 0;
  int errors = 0;

  mcs4_bus_master #(.PHASE_DIV(2), .PC_RESET(12'h000)) dut (
    .sysclk(sysclk), .poc_n(poc_n), .data_i(data_i), .data_o(data_o),
    .data_oe(data_oe), .sync_n(sync_n), .cmrom_n(cmrom_n), .phase(phase),
    .pc(pc), .jmp_valid(jmp_valid), .jmp_addr(jmp_addr), .jmp_ack(jmp_ack),
    .hold(hold), .x_drive(x_drive), .x2_data(x2_data), .x3_data(x3_data),
    .instr_valid(instr_valid), .instr_addr(instr_addr),
    .instr_opr(instr_opr), .instr_opa(instr_opa)
  );

  always #5 sysclk = ~sysclk;

  // ROM responder
  always_comb begin
    data_i = 4'h0;
    if (phase == PH_M1) data_i = 4'hD ^ pc[3:0];
    else if (phase == PH_M2) data_i = 4'h1 + pc[11:8];
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic oe, input logic [3:0] d,
                           input logic s, input logic c);
    check({tag, ".oe"}, {15'd0, data_oe}, {15'd0, oe});
    check({tag, ".data"}, {12'd0, data_o}, {12'd0, d});
    check({tag, ".sync_n"}, {15'd0, sync_n}, {15'd0, s});
    check({tag, ".cmrom_n"}, {15'd0, cmrom_n}, {15'd0, c});
  endtask

  task automatic check_instr(input string tag, input logic [11:0] a,
                             input logic [3:0] r, input logic [3:0] o);
    check({tag, ".valid"}, {15'd0, instr_valid}, 16'd1);
    check({tag, ".addr"}, {4'd0, instr_addr}, {4'd0, a});
    check({tag, ".opr"}, {12'd0, instr_opr}, {12'd0, r});
    check({tag, ".opa"}, {12'd0, instr_opa}, {12'd0, o});
  endtask

  initial begin
    poc_n = 1'b0; hold = 1'b0; jmp_valid = 1'b0; jmp_addr = 12'h000;
    x_drive = 1'b0; x2_data = 4'h0; x3_data = 4'h0;

    // Reset state
    tick(3);
    check("rst.phase", {13'd0, phase}, 16'd0);
    check_bus("rst", 1'b0, 4'h0, 1'b1, 1'b1);
    check("rst.pc", {4'd0, pc}, 16'h000);
    check("rst.ivalid", {15'd0, instr_valid}, 16'd0);
    check("rst.ack", {15'd0, jmp_ack}, 16'd0);
    poc_n = 1'b1;
    tick(1);

    // Cycle 0 at pc=000 (t0)
    check("c0.phase", {13'd0, phase}, 16'd0);
    check_bus("c0.a1", 1'b1, 4'h0, 1'b1, 1'b1);
    tick(2); check_bus("c0.a2", 1'b1, 4'h0, 1'b1, 1'b1);
    tick(2); check_bus("c0.a3", 1'b1, 4'h0, 1'b1, 1'b0);
    tick(1); check("c0.a3b.cmrom", {15'd0, cmrom_n}, 16'd0);
    tick(1); check_bus("c0.m1", 1'b0, 4'h0, 1'b1, 1'b1);
    tick(4); check_instr("c0.instr", 12'h000, 4'hD, 4'h1);
    check("c0.pc_inc", {4'd0, pc}, 16'h001);
    tick(1); check("c0.ivalid_pulse", {15'd0, instr_valid}, 16'd0);
    tick(1); check("c0.x2.oe", {15'd0, data_oe}, 16'd0);
    tick(2); check_bus("c0.x3", 1'b0, 4'h0, 1'b0, 1'b1);

    // Cycle 1 at pc=001 (t1): x_drive on, jump to FFF raised in M1
    tick(2);
    x_drive = 1'b1; x2_data = 4'h3; x3_data = 4'hC;
    check_bus("c1.a1", 1'b1, 4'h1, 1'b1, 1'b1);
    tick(2); check("c1.a2.data", {12'd0, data_o}, 16'h0);
    tick(4);
    jmp_valid = 1'b1; jmp_addr = 12'hFFF;
    tick(4); check_instr("c1.instr", 12'h001, 4'hC, 4'h1);
    check("c1.pc_inc", {4'd0, pc}, 16'h002);
    tick(2); check_bus("c1.x2", 1'b1, 4'h3, 1'b1, 1'b1);
    tick(2); check_bus("c1.x3", 1'b1, 4'hC, 1'b0, 1'b1);
    check("c1.ack_pending", {15'd0, jmp_ack}, 16'd0);
    x_drive = 1'b0;

    // Cycle 2 at pc=FFF (t2)
    tick(2);
    check("c2.ack", {15'd0, jmp_ack}, 16'd1);
    check("c2.pc_jmp", {4'd0, pc}, 16'hFFF);
    check_bus("c2.a1", 1'b1, 4'hF, 1'b1, 1'b1);
    jmp_valid = 1'b0;
    tick(1); check("c2.ack_pulse", {15'd0, jmp_ack}, 16'd0);
    tick(1); check("c2.a2.data", {12'd0, data_o}, 16'hF);
    tick(2); check("c2.a3.data", {12'd0, data_o}, 16'hF);
    tick(2);
    jmp_valid = 1'b1; jmp_addr = 12'h2A5;
    tick(4); check_instr("c2.instr", 12'hFFF, 4'h2, 4'h0);
    check("c2.pc_wrap", {4'd0, pc}, 16'h000);
    tick(2); check("c2.x2.oe", {15'd0, data_oe}, 16'd0);
    tick(2); check("c2.x3.oe", {15'd0, data_oe}, 16'd0);
    hold = 1'b1;

    // WAIT with jump pending
    tick(2);
    check("w.phase", {13'd0, phase}, 16'd7);
    check_bus("w.enter", 1'b0, 4'h0, 1'b1, 1'b1);
    check("w.ack", {15'd0, jmp_ack}, 16'd0);
    check("w.pc", {4'd0, pc}, 16'h000);
    tick(9);
    check("w.late.phase", {13'd0, phase}, 16'd7);
    check_bus("w.late", 1'b0, 4'h0, 1'b1, 1'b1);
    hold = 1'b0;

    // Cycle 3 at pc=2A5 (t3)
    tick(1);
    check("c3.phase", {13'd0, phase}, 16'd0);
    check("c3.ack", {15'd0, jmp_ack}, 16'd1);
    check_bus("c3.a1", 1'b1, 4'h5, 1'b1, 1'b1);
    jmp_valid = 1'b0;
    tick(1); check("c3.ack_pulse", {15'd0, jmp_ack}, 16'd0);
    tick(1); check("c3.a2.data", {12'd0, data_o}, 16'hA);
    tick(2); check("c3.a3.data", {12'd0, data_o}, 16'h2);

    // Reset during M2
    tick(4);
    check("c3.m2.phase", {13'd0, phase}, 16'd4);
    poc_n = 1'b0;
    tick(1);
    check("mr.phase", {13'd0, phase}, 16'd0);
    check_bus("mr", 1'b0, 4'h0, 1'b1, 1'b1);
    check("mr.pc", {4'd0, pc}, 16'h000);
    check("mr.ivalid", {15'd0, instr_valid}, 16'd0);
    check("mr.iaddr", {4'd0, instr_addr}, 16'h000);
    check("mr.iopr", {12'd0, instr_opr}, 16'h0);
    check("mr.iopa", {12'd0, instr_opa}, 16'h0);
    tick(1);
    check("mr.ivalid2", {15'd0, instr_valid}, 16'd0);
    poc_n = 1'b1;
    tick(1);
    check_bus("rs.a1", 1'b1, 4'h0, 1'b1, 1'b1);
    check("rs.ack", {15'd0, jmp_ack}, 16'd0);
    tick(10);
    check_instr("rs.instr", 12'h000, 4'hD, 4'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
